// File: rtl/request_queue_arbiter_if.sv
// Bus between N requesters and the arrival-order arbiter.
// The arbiter connects to the slave modport. The requester side, or a bench, connects to master.
interface request_queue_arbiter_if #(
  parameter int N = 4
) ();
  localparam int ID_W = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [ID_W-1:0] grant_id;
  logic [N-1:0]  pending;
  logic [ID_W:0] queue_count;

  modport master (
    output req,
    input  grant, grant_valid, grant_id, pending, queue_count
  );

  modport slave (
    input  req,
    output grant, grant_valid, grant_id, pending, queue_count
  );
endinterface

// File: rtl/request_queue_arbiter.sv
// N-way arbiter that serves requesters in the order their requests arrive.
// Each grant is registered, one-hot and held for HOLD cycles.
// Consecutive grants hand off back-to-back with no idle cycle between them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; grant is zero and the queue is empty
// S_GRANT | one requester owns the resource; cnt_q counts down the cycles left
module request_queue_arbiter #(
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input logic                    clock,
  input logic                    reset,
  request_queue_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(N);
  // Storage is rounded up to a power of two so that the ID_W-bit tail index
  // can never address past the array. Slots at N and above never fill,
  // because each requester holds at most one slot.
  localparam int DEPTH = 1 << ID_W;
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ID_W:0]    QC_ONE    = (ID_W + 1)'(1);
  localparam logic [N-1:0]     ONE_N     = N'(1);

  logic [0:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [ID_W-1:0] fifo_q [DEPTH];
  logic [ID_W-1:0] fifo_d [DEPTH];
  logic [ID_W:0]   count_q, count_d;

  logic [N-1:0]    elig;
  logic [N-1:0]    push_vec;
  logic [ID_W-1:0] low_id;
  logic            last_cycle;
  logic            choose;
  logic            pop;

  // Next-state logic: pick the next owner, pop the queue head, and append new arrivals in index order.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    pending_d = pending_q;
    count_d   = count_q;
    fifo_d    = fifo_q;
    pop       = 1'b0;
    low_id    = '0;

    last_cycle = (state_q == S_GRANT) && (cnt_q == '0);
    choose     = (state_q == S_IDLE) || last_cycle;

    // The current owner may re-queue only on its last grant cycle.
    elig     = bus.req & ~pending_q & ~(grant_q & {N{~last_cycle}});
    push_vec = elig;

    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        low_id = ID_W'(i);
      end
    end

    if (choose) begin
      if (count_q != '0) begin
        pop       = 1'b1;
        gid_d     = fifo_q[0];
        grant_d   = ONE_N << fifo_q[0];
        pending_d = pending_q & ~(ONE_N << fifo_q[0]);
        state_d   = S_GRANT;
        cnt_d     = HOLD_LOAD;
      end else if (elig != '0) begin
        gid_d    = low_id;
        grant_d  = ONE_N << low_id;
        push_vec = elig & ~(ONE_N << low_id);
        state_d  = S_GRANT;
        cnt_d    = HOLD_LOAD;
      end else begin
        gid_d   = '0;
        grant_d = '0;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end

    if (pop) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        fifo_d[j] = fifo_q[j + 1];
      end
      fifo_d[DEPTH - 1] = '0;
      count_d = count_q - QC_ONE;
    end

    for (int i = 0; i < N; i++) begin
      if (push_vec[i]) begin
        fifo_d[count_d[ID_W-1:0]] = ID_W'(i);
        count_d      = count_d + QC_ONE;
        pending_d[i] = 1'b1;
      end
    end
  end

  // State registers: reset clears everything at once, and the queue contents are discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      gid_q     <= '0;
      pending_q <= '0;
      count_q   <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        fifo_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      fifo_q    <= fifo_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == S_GRANT);
  assign bus.grant_id    = gid_q;
  assign bus.pending     = pending_q;
  assign bus.queue_count = count_q;
endmodule

// File: tb/tb_request_queue_arbiter.sv
// Bench for request_queue_arbiter. Three instances (HOLD = 1, 3, 4) share clock, reset and req.
// Each instance is compared every cycle against a queue model of arrival-order service.
module tb_request_queue_arbiter;
  localparam int N = 4;
  localparam int K = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;

  always #5 clock = ~clock;

  request_queue_arbiter_if #(.N(N)) bus_h1 ();
  request_queue_arbiter_if #(.N(N)) bus_h3 ();
  request_queue_arbiter_if #(.N(N)) bus_h4 ();

  assign bus_h1.req = req;
  assign bus_h3.req = req;
  assign bus_h4.req = req;

  request_queue_arbiter #(.N(N), .HOLD(1)) u_h1 (.clock(clock), .reset(reset), .bus(bus_h1.slave));
  request_queue_arbiter #(.N(N), .HOLD(3)) u_h3 (.clock(clock), .reset(reset), .bus(bus_h3.slave));
  request_queue_arbiter #(.N(N), .HOLD(4)) u_h4 (.clock(clock), .reset(reset), .bus(bus_h4.slave));

  logic [N-1:0] d_grant [K];
  logic [N-1:0] d_pend  [K];
  logic [1:0]   d_id    [K];
  logic [2:0]   d_cnt   [K];
  logic         d_valid [K];

  assign d_grant[0] = bus_h1.grant;  assign d_grant[1] = bus_h3.grant;  assign d_grant[2] = bus_h4.grant;
  assign d_pend[0]  = bus_h1.pending; assign d_pend[1] = bus_h3.pending; assign d_pend[2]  = bus_h4.pending;
  assign d_id[0]    = bus_h1.grant_id; assign d_id[1]  = bus_h3.grant_id; assign d_id[2]   = bus_h4.grant_id;
  assign d_cnt[0]   = bus_h1.queue_count; assign d_cnt[1] = bus_h3.queue_count; assign d_cnt[2] = bus_h4.queue_count;
  assign d_valid[0] = bus_h1.grant_valid; assign d_valid[1] = bus_h3.grant_valid; assign d_valid[2] = bus_h4.grant_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance: current owner (-1 = idle), grant cycles left, and the FIFO of queued ids.
  int owner     [K];
  int hold_left [K];
  int mq        [K][N];
  int mcnt      [K];

  function automatic int hold_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (HOLD=%0d) at %0t: got %0h, expected %0h", name, hold_of(k), $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < K; k++) begin
      owner[k]     = -1;
      hold_left[k] = 0;
      mcnt[k]      = 0;
      for (int j = 0; j < N; j++) mq[k][j] = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic [N-1:0] r);
    int  el[$];
    bit  last, choose, inq;
    last   = (owner[k] >= 0) && (hold_left[k] == 0);
    choose = (owner[k] < 0) || last;
    for (int i = 0; i < N; i++) begin
      inq = 1'b0;
      for (int j = 0; j < mcnt[k]; j++) if (mq[k][j] == i) inq = 1'b1;
      if (r[i] && !inq && !(i == owner[k] && !last)) el.push_back(i);
    end
    if (choose) begin
      if (mcnt[k] > 0) begin
        owner[k] = mq[k][0];
        for (int j = 0; j < N - 1; j++) mq[k][j] = mq[k][j + 1];
        mcnt[k]--;
        hold_left[k] = hold_of(k) - 1;
      end else if (el.size() > 0) begin
        owner[k]     = el.pop_front();
        hold_left[k] = hold_of(k) - 1;
      end else begin
        owner[k]     = -1;
        hold_left[k] = 0;
      end
    end else begin
      hold_left[k]--;
    end
    foreach (el[j]) begin
      mq[k][mcnt[k]] = el[j];
      mcnt[k]++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg, ep;
    for (int k = 0; k < K; k++) begin
      eg = (owner[k] >= 0) ? (N'(1) << owner[k]) : '0;
      ep = '0;
      for (int j = 0; j < mcnt[k]; j++) ep[mq[k][j]] = 1'b1;
      chk("grant",       k, 32'(d_grant[k]), 32'(eg));
      chk("grant_valid", k, 32'(d_valid[k]), 32'(owner[k] >= 0));
      chk("grant_id",    k, 32'(d_id[k]),    32'((owner[k] >= 0) ? owner[k] : 0));
      chk("pending",     k, 32'(d_pend[k]),  32'(ep));
      chk("queue_count", k, 32'(d_cnt[k]),   32'(mcnt[k]));
    end
  endtask

  // Drive req at the falling edge, advance the model at the rising edge, and compare 1 time unit later.
  task automatic step(input logic [N-1:0] r);
    @(negedge clock);
    req = r;
    @(posedge clock);
    if (reset) model_clear();
    else for (int k = 0; k < K; k++) model_edge(k, req);
    #1;
    compare_all();
  endtask

  // Reset pulse between clock edges; outputs must clear without waiting for an edge.
  task automatic pulse_reset();
    #1 reset = 1'b1;
    model_clear();
    #1 compare_all();
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) step('0);
  endtask

  initial begin
    model_clear();

    // Reset held while all four requesters assert, then the first edge after release.
    step(4'b1111);
    chk("t1_reset_grant", 0, 32'(d_grant[0]), 32'h0);
    chk("t1_reset_count", 0, 32'(d_cnt[0]),   32'h0);
    chk("t1_reset_pend",  0, 32'(d_pend[0]),  32'h0);
    #3 reset = 1'b0;
    step(4'b1111);
    chk("t1_first_grant", 0, 32'(d_grant[0]), 32'h1);
    chk("t1_first_pend",  0, 32'(d_pend[0]),  32'he);
    chk("t1_first_count", 0, 32'(d_cnt[0]),   32'h3);
    drain(20);
    chk("t1_drained", 2, 32'(d_grant[2]), 32'h0);

    // A single one-cycle request.
    step(4'b0001);
    chk("t2_grant", 0, 32'(d_grant[0]), 32'h1);
    step(4'b0000);
    chk("t2_release", 0, 32'(d_grant[0]), 32'h0);
    drain(6);

    // A simultaneous pair; requester 1 is still served after its req has dropped.
    step(4'b0011);
    chk("t3_grant0", 0, 32'(d_grant[0]), 32'h1);
    chk("t3_count",  0, 32'(d_cnt[0]),   32'h1);
    chk("t3_pend",   0, 32'(d_pend[0]),  32'h2);
    step(4'b0000);
    chk("t3_grant1", 0, 32'(d_grant[0]), 32'h2);
    step(4'b0000);
    chk("t3_idle",   0, 32'(d_grant[0]), 32'h0);
    drain(12);

    // Arrival order with HOLD=3: requester 3 first, then requester 1, handed off with no gap.
    step(4'b1000);
    chk("t4_g3_a", 1, 32'(d_grant[1]), 32'h8);
    step(4'b0010);
    chk("t4_g3_b", 1, 32'(d_grant[1]), 32'h8);
    chk("t4_pend", 1, 32'(d_pend[1]),  32'h2);
    step(4'b0000);
    chk("t4_g3_c", 1, 32'(d_grant[1]), 32'h8);
    for (int c = 0; c < 3; c++) begin
      step(4'b0000);
      chk("t4_g1", 1, 32'(d_grant[1]), 32'h2);
    end
    step(4'b0000);
    chk("t4_idle", 1, 32'(d_grant[1]), 32'h0);
    drain(16);

    // Persistent contention with HOLD=1: round-robin in arrival order.
    for (int s = 0; s < 8; s++) begin
      step(4'b1111);
      chk("t5_grant", 0, 32'(d_grant[0]), 32'(4'b0001 << (s % 4)));
      chk("t5_count", 0, 32'(d_cnt[0]),   32'h3);
      chk("t5_valid", 0, 32'(d_valid[0]), 32'h1);
    end
    drain(24);

    // Async reset in the 2nd cycle of grant 0100 (HOLD=4) with two entries queued.
    step(4'b0100);
    chk("t6_grant", 2, 32'(d_grant[2]), 32'h4);
    step(4'b0011);
    chk("t6_count_before", 2, 32'(d_cnt[2]), 32'h2);
    #1 reset = 1'b1;
    model_clear();
    #1;
    chk("t6_async_grant", 2, 32'(d_grant[2]), 32'h0);
    chk("t6_async_count", 2, 32'(d_cnt[2]),   32'h0);
    compare_all();
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(4'b0000);
      chk("t6_stays_idle", 2, 32'(d_valid[2]), 32'h0);
    end

    // Random traffic, with quiet stretches and occasional mid-cycle resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) step('0);
      else step(N'($urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
